// File: rtl/zest_spi_sched.sv
// zest_spi_sched: shares one SPI master between local-bus host words and a periodic poll table.
// Define ZEST_SPI_SCHED_TIMEOUT_EN to add a 4096-cycle WAIT watchdog that drives the timeout output.
module zest_spi_sched #(
  parameter int DW     = 24,
  parameter int NSLOT  = 4,
  parameter int PW     = 16,
  parameter int HBURST = 4
) (
  input  logic                lb_clk,
  input  logic                reset,
  input  logic                host_req,
  input  logic [DW-1:0]       host_word,
  output logic                host_ack,
  output logic                host_done,
  output logic [DW-1:0]       host_rdata,
  input  logic [NSLOT*DW-1:0] poll_words,
  input  logic [NSLOT-1:0]    poll_en,
  input  logic [PW-1:0]       poll_period,
  output logic                poll_valid,
  output logic [2:0]          poll_idx,
  output logic [DW-1:0]       poll_data,
  output logic                spi_start,
  output logic [DW-1:0]       spi_word,
  input  logic                spi_done,
  input  logic [DW-1:0]       spi_rdata,
  output logic                overrun,
  output logic                timeout,
  input  logic                err_clr
);

  localparam int HCW = $clog2(HBURST + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    cnt;
  logic             pending;
  logic [NSLOT-1:0] rem;
  logic [HCW-1:0]   host_cnt;
  logic             owner_host;
  logic [2:0]       cur_slot;

  logic [3:0]       first;
  logic [2:0]       pick_slot;
  logic             slot_any;
  logic [NSLOT-1:0] next_rem;
  logic [DW-1:0]    pick_word;
  logic             grant_host;
  logic             grant_poll;
  logic             expire;
  logic             timeout_hit;
  logic             xfer_end;
  logic             round_done;
  logic             start_round;
  logic [DW-1:0]    rdata_in;

  // Lowest remaining slot of the current round: {found, index}.
  function automatic logic [3:0] first_slot(input logic [NSLOT-1:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (m[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign first     = first_slot(rem);
  assign slot_any  = first[3];
  assign pick_slot = first[2:0];

  always_comb begin
    next_rem  = rem;
    pick_word = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (pick_slot == 3'(i)) begin
        next_rem[i] = 1'b0;
        pick_word   = poll_words[i*DW +: DW];
      end
    end
  end

  // Host wins unless a round is pending and the host has used up its burst allowance.
  assign grant_host  = (state == S_IDLE) && host_req &&
                       (!pending || (host_cnt < HCW'(HBURST)));
  assign grant_poll  = (state == S_IDLE) && !grant_host && pending && slot_any;
  assign expire      = (poll_period != '0) && (cnt == PW'(1));
  assign xfer_end    = (state == S_WAIT) && (spi_done || timeout_hit);
  assign round_done  = xfer_end && !owner_host && (rem == '0);
  assign start_round = expire && (!pending || round_done);
  assign rdata_in    = ((state == S_WAIT) && spi_done) ? spi_rdata : '0;

  // Period counter and round bookkeeping.
  always_ff @(posedge lb_clk or posedge reset) begin
    if (reset) begin
      cnt     <= poll_period;
      pending <= 1'b0;
      rem     <= '0;
      overrun <= 1'b0;
    end else begin
      if (poll_period == '0) cnt <= '0;
      else if (cnt <= PW'(1)) cnt <= poll_period;
      else cnt <= cnt - PW'(1);

      if (err_clr) overrun <= 1'b0;
      else if (expire && pending && !round_done) overrun <= 1'b1;

      // poll_en is captured once per round; an empty table never raises pending.
      if (start_round) begin
        pending <= |poll_en;
        rem     <= poll_en;
      end else begin
        if (round_done) pending <= 1'b0;
        if (grant_poll) rem <= next_rem;
      end
    end
  end

  // Transaction FSM with registered handshakes.
  always_ff @(posedge lb_clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      spi_start  <= 1'b0;
      spi_word   <= '0;
      host_ack   <= 1'b0;
      host_done  <= 1'b0;
      host_rdata <= '0;
      poll_valid <= 1'b0;
      poll_idx   <= '0;
      poll_data  <= '0;
      host_cnt   <= '0;
      owner_host <= 1'b0;
      cur_slot   <= '0;
    end else begin
      spi_start  <= 1'b0;
      host_ack   <= 1'b0;
      host_done  <= 1'b0;
      poll_valid <= 1'b0;

      if (!pending || grant_poll) host_cnt <= '0;
      else if (grant_host) host_cnt <= host_cnt + HCW'(1);

      case (state)
        S_IDLE: begin
          if (grant_host) begin
            state      <= S_ISSUE;
            spi_start  <= 1'b1;
            host_ack   <= 1'b1;
            spi_word   <= host_word;
            owner_host <= 1'b1;
          end else if (grant_poll) begin
            state      <= S_ISSUE;
            spi_start  <= 1'b1;
            spi_word   <= pick_word;
            owner_host <= 1'b0;
            cur_slot   <= pick_slot;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (xfer_end) begin
            state <= S_IDLE;
            if (owner_host) begin
              host_done  <= 1'b1;
              host_rdata <= rdata_in;
            end else begin
              poll_valid <= 1'b1;
              poll_idx   <= cur_slot;
              poll_data  <= rdata_in;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ZEST_SPI_SCHED_TIMEOUT_EN
  logic [11:0] wdog;

  // Watchdog: the 4096th WAIT cycle without spi_done ends the transaction with zero data.
  always_ff @(posedge lb_clk or posedge reset) begin
    if (reset) begin
      wdog    <= '0;
      timeout <= 1'b0;
    end else begin
      if ((state == S_WAIT) && !spi_done) wdog <= wdog + 12'd1;
      else wdog <= '0;

      if (err_clr) timeout <= 1'b0;
      else if (timeout_hit) timeout <= 1'b1;
    end
  end

  assign timeout_hit = (state == S_WAIT) && !spi_done && (wdog == 12'hFFF);
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_zest_spi_sched.sv
// Directed bench for zest_spi_sched: SPI master model plus a scoreboard of host and poll readback.
module tb_zest_spi_sched;
  localparam int DW = 24;
  localparam int NSLOT = 4;
  localparam int PW = 16;
  localparam int HBURST = 4;
  localparam logic [DW-1:0] MASK = 24'h5A5A5A;

  logic                lb_clk = 1'b0;
  logic                reset = 1'b1;
  logic                host_req = 1'b0;
  logic [DW-1:0]       host_word;
  logic                host_ack;
  logic                host_done;
  logic [DW-1:0]       host_rdata;
  logic [NSLOT*DW-1:0] poll_words;
  logic [NSLOT-1:0]    poll_en;
  logic [PW-1:0]       poll_period;
  logic                poll_valid;
  logic [2:0]          poll_idx;
  logic [DW-1:0]       poll_data;
  logic                spi_start;
  logic [DW-1:0]       spi_word;
  logic                spi_done = 1'b0;
  logic [DW-1:0]       spi_rdata;
  logic                overrun;
  logic                timeout;
  logic                err_clr;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int n, p, nh;
  logic [DW-1:0] hq[$];
  logic [DW+2:0] pq[$];
  int log_cyc[$];
  bit log_host[$];
  int v0q[$];
  bit m_busy = 1'b0;
  bit m_hang = 1'b0;
  bit exp_zero = 1'b0;
  int m_cnt = 0;
  int m_delay = 4;
  logic [DW-1:0] m_word = '0;

  zest_spi_sched #(.DW(DW), .NSLOT(NSLOT), .PW(PW), .HBURST(HBURST)) dut (
    .lb_clk(lb_clk), .reset(reset),
    .host_req(host_req), .host_word(host_word), .host_ack(host_ack),
    .host_done(host_done), .host_rdata(host_rdata),
    .poll_words(poll_words), .poll_en(poll_en), .poll_period(poll_period),
    .poll_valid(poll_valid), .poll_idx(poll_idx), .poll_data(poll_data),
    .spi_start(spi_start), .spi_word(spi_word), .spi_done(spi_done), .spi_rdata(spi_rdata),
    .overrun(overrun), .timeout(timeout), .err_clr(err_clr)
  );

  always #5 lb_clk = ~lb_clk;

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish, observed timeout expected completion");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] pw(input int i);
    return poll_words[i*DW +: DW];
  endfunction

  task automatic push_poll(input int slot);
    pq.push_back({3'(slot), pw(slot) ^ MASK});
  endtask

  // One clock: sample outputs 1 time unit after the edge, score, then advance the SPI master model.
  task automatic tick();
    logic [DW+2:0] pe;
    @(posedge lb_clk);
    #1;
    cyc++;
    if (host_done) begin
      chk("host_done_expected", 64'(hq.size() != 0), 64'd1);
      if (hq.size() != 0) chk("host_rdata", 64'(host_rdata), 64'(hq.pop_front()));
    end
    if (poll_valid) begin
      chk("poll_valid_expected", 64'(pq.size() != 0), 64'd1);
      if (pq.size() != 0) begin
        pe = pq.pop_front();
        chk("poll_idx", 64'(poll_idx), 64'(pe[DW+2:DW]));
        chk("poll_data", 64'(poll_data), 64'(pe[DW-1:0]));
      end
      if (poll_idx == 3'd0) v0q.push_back(cyc);
    end
    if (host_ack) hq.push_back(exp_zero ? '0 : (host_word ^ MASK));
    spi_done = 1'b0;
    if (spi_start) begin
      log_cyc.push_back(cyc);
      log_host.push_back(host_ack);
      m_busy = 1'b1;
      m_cnt  = m_delay;
      m_word = spi_word;
    end else if (m_busy && !m_hang) begin
      m_cnt--;
      if (m_cnt == 0) begin
        chk("spi_word_stable", 64'(spi_word), 64'(m_word));
        spi_done  = 1'b1;
        spi_rdata = m_word ^ MASK;
        m_busy    = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input logic [PW-1:0] per, input logic [NSLOT-1:0] en, input int dly);
    reset = 1'b1;
    poll_period = per;
    poll_en = en;
    m_delay = dly;
    m_busy = 1'b0;
    m_hang = 1'b0;
    spi_done = 1'b0;
    hq.delete();
    pq.delete();
    log_cyc.delete();
    log_host.delete();
    v0q.delete();
    tick();
    tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic drain(input string tag, input int limit);
    int k;
    k = 0;
    while ((hq.size() != 0 || pq.size() != 0) && k < limit) begin
      tick();
      k++;
    end
    chk({tag, "_drained"}, 64'(hq.size() + pq.size()), 64'd0);
  endtask

  initial begin
    host_word = '0;
    err_clr = 1'b0;
    spi_rdata = '0;
    poll_en = '0;
    poll_period = '0;
    poll_words = {24'h44D4D4, 24'h33C3C3, 24'h22B2B2, 24'h11A1A1};

    // Reset state
    tick();
    tick();
    chk("rst_host_ack", 64'(host_ack), 64'd0);
    chk("rst_host_done", 64'(host_done), 64'd0);
    chk("rst_poll_valid", 64'(poll_valid), 64'd0);
    chk("rst_spi_start", 64'(spi_start), 64'd0);
    chk("rst_spi_word", 64'(spi_word), 64'd0);
    chk("rst_host_rdata", 64'(host_rdata), 64'd0);
    chk("rst_poll_data", 64'(poll_data), 64'd0);
    chk("rst_poll_idx", 64'(poll_idx), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);

    // Host request on the same cycle as period expiry: host first, then the poll
    do_reset(16'd50, 4'b0001, 5);
    for (int i = 0; i < 49; i++) tick();
    host_word = 24'hC0FFEE;
    host_req = 1'b1;
    tick();
    chk("tie_host_ack", 64'(host_ack), 64'd1);
    chk("tie_spi_start", 64'(spi_start), 64'd1);
    chk("tie_spi_word", 64'(spi_word), 64'h00C0FFEE);
    host_req = 1'b0;
    push_poll(0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!spi_start && n < 50);
    chk("tie_poll_start", 64'(spi_start), 64'd1);
    chk("tie_poll_cycle", 64'(cyc), 64'd57);
    chk("tie_poll_no_ack", 64'(host_ack), 64'd0);
    chk("tie_poll_word", 64'(spi_word), 64'(pw(0)));
    drain("tie", 100);
    poll_period = '0;

    // Stray spi_done while idle
    tick();
    spi_rdata = 24'hBADBAD;
    spi_done = 1'b1;
    tick();
    chk("stray_host_done", 64'(host_done), 64'd0);
    chk("stray_poll_valid", 64'(poll_valid), 64'd0);
    chk("stray_host_rdata", 64'(host_rdata), 64'(24'hC0FFEE ^ MASK));

    // Empty poll table: no transactions, no overrun
    do_reset(16'd10, 4'b0000, 4);
    for (int i = 0; i < 40; i++) tick();
    chk("zero_en_starts", 64'(log_cyc.size()), 64'd0);
    chk("zero_en_overrun", 64'(overrun), 64'd0);

    // Two poll rounds of slots 0 and 2, 100 cycles apart
    do_reset(16'd100, 4'b0101, 10);
    push_poll(0);
    push_poll(2);
    push_poll(0);
    push_poll(2);
    drain("rounds", 400);
    chk("rounds_count", 64'(v0q.size()), 64'd2);
    if (v0q.size() >= 2) begin
      chk("rounds_first_cycle", 64'(v0q[0]), 64'd112);
      chk("rounds_spacing", 64'(v0q[1] - v0q[0]), 64'd100);
    end
    chk("rounds_starts", 64'(log_cyc.size()), 64'd4);
    chk("rounds_overrun", 64'(overrun), 64'd0);
    poll_period = '0;
    for (int i = 0; i < 120; i++) tick();

    // Continuous host traffic against a pending round
    host_word = 24'h0A0B0C;
    host_req = 1'b1;
    do_reset(16'd40, 4'b0010, 3);
    push_poll(1);
    for (int i = 0; i < 70; i++) tick();
    host_req = 1'b0;
    poll_period = '0;
    drain("burst", 100);
    p = -1;
    for (int i = 0; i < log_cyc.size(); i++) begin
      if (p < 0 && !log_host[i]) p = i;
    end
    chk("burst_poll_seen", 64'(p >= 0), 64'd1);
    if (p >= 0) begin
      nh = 0;
      for (int i = 0; i < p; i++) begin
        if (log_cyc[i] > 40) nh++;
      end
      chk("burst_host_count", 64'(nh), 64'(HBURST));
      chk("burst_poll_cycle", 64'(log_cyc[p]), 64'd61);
      chk("burst_host_resumes", 64'((p + 1 < log_cyc.size()) ? log_host[p+1] : 1'b0), 64'd1);
    end

    // Overrun on a slow SPI master, err_clr, and err_clr beating a simultaneous set
    do_reset(16'd20, 4'b0001, 30);
    push_poll(0);
    push_poll(0);
    for (int i = 0; i < 39; i++) tick();
    chk("ovr_before", 64'(overrun), 64'd0);
    tick();
    chk("ovr_set", 64'(overrun), 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovr_cleared", 64'(overrun), 64'd0);
    while (cyc < 79) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovr_clr_wins", 64'(overrun), 64'd0);
    tick();
    chk("ovr_stays_clear", 64'(overrun), 64'd0);
    poll_period = '0;
    drain("ovr", 200);

    // Reset while waiting on the SPI master
    do_reset(16'd0, 4'b0000, 4);
    host_word = 24'h123456;
    host_req = 1'b1;
    tick();
    chk("pre_ack", 64'(host_ack), 64'd1);
    host_req = 1'b0;
    drain("pre", 50);
    host_word = 24'h654321;
    host_req = 1'b1;
    m_hang = 1'b1;
    tick();
    chk("inflight_ack", 64'(host_ack), 64'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("inflight_word", 64'(spi_word), 64'h00654321);
    #1 reset = 1'b1;
    #1;
    chk("async_spi_word", 64'(spi_word), 64'd0);
    chk("async_host_rdata", 64'(host_rdata), 64'd0);
    chk("async_spi_start", 64'(spi_start), 64'd0);
    chk("async_host_done", 64'(host_done), 64'd0);
    chk("async_overrun", 64'(overrun), 64'd0);
    hq.delete();
    m_busy = 1'b0;
    m_hang = 1'b0;
    tick();
    chk("reset_no_done", 64'(host_done), 64'd0);
    reset = 1'b0;
    cyc = 0;
    tick();
    chk("rearb_ack", 64'(host_ack), 64'd1);
    chk("rearb_word", 64'(spi_word), 64'h00654321);
    host_req = 1'b0;
    drain("rearb", 50);

`ifdef ZEST_SPI_SCHED_TIMEOUT_EN
    // Watchdog on a master that never answers
    do_reset(16'd0, 4'b0000, 4);
    m_hang = 1'b1;
    exp_zero = 1'b1;
    host_word = 24'h777777;
    host_req = 1'b1;
    tick();
    chk("wd_ack", 64'(host_ack), 64'd1);
    host_req = 1'b0;
    n = 0;
    while (!host_done && n < 5000) begin
      tick();
      n++;
    end
    chk("wd_done_seen", 64'(host_done), 64'd1);
    chk("wd_latency", 64'(cyc), 64'd4098);
    chk("wd_timeout", 64'(timeout), 64'd1);
    chk("wd_rdata", 64'(host_rdata), 64'd0);
    exp_zero = 1'b0;
    m_hang = 1'b0;
    m_busy = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("wd_timeout_clr", 64'(timeout), 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/zest_spi_sched.md
ZEST_SPI_SCHED -- requirements
Module: zest_spi_sched

Interface
REQ-001 SHALL have parameter DW, default 24: SPI word width in bits.
REQ-002 SHALL have parameter NSLOT, default 4: number of poll slots, 1..8.
REQ-003 SHALL have parameter PW, default 16: poll-period counter width.
REQ-004 SHALL have parameter HBURST, default 4: maximum consecutive host transactions while a poll round is pending.
REQ-005 SHALL have port lb_clk, input, 1 bit: the single clock, rising edge; already decided.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset; already decided.
REQ-007 SHALL have port host_req, input, 1 bit: local-bus SPI request, level, held until host_ack.
REQ-008 SHALL have port host_word, input, DW bits: host SPI word, sampled on host_ack.
REQ-009 SHALL have port host_ack, output, 1 bit: 1-cycle pulse when a host word is issued.
REQ-010 SHALL have port host_done, output, 1 bit: 1-cycle pulse when the host transaction completes.
REQ-011 SHALL have port host_rdata, output, DW bits: readback for the last host transaction.
REQ-012 SHALL have port poll_words, input, NSLOT*DW bits: poll command table; slot i at bits [i*DW +: DW].
REQ-013 SHALL have port poll_en, input, NSLOT bits: per-slot enable.
REQ-014 SHALL have port poll_period, input, PW bits: lb_clk cycles between poll rounds; 0 disables polling.
REQ-015 SHALL have port poll_valid, output, 1 bit: 1-cycle pulse, poll result present.
REQ-016 SHALL have port poll_idx, output, 3 bits: slot index of the poll result.
REQ-017 SHALL have port poll_data, output, DW bits: poll readback.
REQ-018 SHALL have port spi_start, output, 1 bit: 1-cycle pulse to the shared SPI master.
REQ-019 SHALL have port spi_word, output, DW bits: word to the SPI master, stable from spi_start through spi_done.
REQ-020 SHALL have port spi_done, input, 1 bit: 1-cycle completion pulse from the SPI master.
REQ-021 SHALL have port spi_rdata, input, DW bits: SPI master readback, valid with spi_done.
REQ-022 SHALL have port overrun, output, 1 bit: sticky; a period expired while a round was still pending.
REQ-023 SHALL have port err_clr, input, 1 bit: clears overrun and timeout.

Function
REQ-024 SHALL run the FSM IDLE->ISSUE->WAIT->IDLE; ISSUE lasts 1 cycle, asserts spi_start, and registers spi_word.
REQ-025 SHALL pick a requester in IDLE each cycle: host if host_req and (no round pending, or host_cnt<HBURST); otherwise poll if a round is pending.
REQ-026 SHALL assert host_ack in the same cycle as the ISSUE that carries the host word.
REQ-027 SHALL, on spi_done in WAIT: latch spi_rdata into host_rdata or poll_data on the next edge, pulse host_done or poll_valid, and return to IDLE (latency 1 cycle).
REQ-028 SHALL increment host_cnt on each host grant while a round is pending, and clear it on any poll grant or when no round is pending.
REQ-029 SHALL run the period counter from poll_period down to 1; at expiry it sets pending and reloads; expiry while pending already set sets overrun and does not start a second round.
REQ-030 SHALL make a poll round issue the enabled slots in ascending index, one transaction each, clear pending after the last enabled slot, and clear pending immediately if poll_en is all zero.
REQ-031 SHALL sample poll_en at the start of the round; changes mid-round take effect the next round.
REQ-032 SHALL treat poll_period=0 as holding the counter at 0 with no new rounds; an in-progress round completes.
REQ-033 SHALL ignore spi_done outside WAIT.
REQ-034 SHALL let err_clr win over a simultaneous overrun set.

Reset
REQ-035 SHALL, on reset: enter IDLE; clear host_ack, host_done, poll_valid, spi_start, overrun, timeout, pending, host_cnt and slot pointer; zero spi_word, host_rdata, poll_data and poll_idx; load the counter with poll_period.
REQ-036 SHALL abandon a transaction in flight at reset with no done pulse; a held host_req re-arbitrates after reset.

Configuration
REQ-037 SHALL, with ZEST_SPI_SCHED_TIMEOUT_EN defined: count cycles in WAIT; at 4096 with no spi_done, set a sticky timeout output, pulse the owner's done/valid with rdata zeroed, return to IDLE.
REQ-038 SHALL, without ZEST_SPI_SCHED_TIMEOUT_EN: omit the watchdog, tie timeout to 0, and wait indefinitely in WAIT.

Verification
REQ-039 SHALL test: poll_period=100, poll_en=4'b0101, SPI done 10 cycles after start -> slots 0 then 2 issued per round, poll_idx 0,2, rounds 100 cycles apart.
REQ-040 SHALL test: host_req held continuously, round pending, HBURST=4 -> 4 host acks, then 1 poll, then host resumes.
REQ-041 SHALL test: poll_period=20, SPI done 30 cycles after start -> overrun=1 after the second expiry; err_clr -> 0.
REQ-042 SHALL test: reset asserted in WAIT -> FSM IDLE, no done pulse, all outputs at reset values asynchronously.
REQ-043 SHALL test, with the macro defined: spi_done never returned -> after 4096 cycles, timeout=1, host_done pulses, host_rdata=0.
REQ-044 SHALL test: host_req and period expiry in the same cycle with pending clear -> host granted first, poll next.
